// File: rtl/icache_refill.sv
// rtl/icache_refill.sv - icache miss refill engine: one AXI4 read burst per line, then data/tag array write
// Optional feature macro: ICACHE_REFILL_WRAP_EN (critical-word-first WRAP burst)
module icache_refill #(
    parameter int IDX_LEN = 5,
    parameter int BLK_LEN = 4,
    parameter int BUS_W   = 64
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            req_valid_i,
    output logic                            req_ready_o,
    input  logic [31:0]                     req_addr_i,
    output logic                            arvalid_o,
    input  logic                            arready_i,
    output logic [31:0]                     araddr_o,
    output logic [7:0]                      arlen_o,
    output logic [2:0]                      arsize_o,
    output logic [1:0]                      arburst_o,
    input  logic                            rvalid_i,
    output logic                            rready_o,
    input  logic [BUS_W-1:0]                rdata_i,
    input  logic [1:0]                      rresp_i,
    input  logic                            rlast_i,
    output logic                            line_wen_o,
    output logic [IDX_LEN-1:0]              line_index_o,
    output logic [127:0]                    line_wdata_o,
    output logic [127:0]                    line_wmask_o,
    output logic                            tag_wen_o,
    output logic [31-IDX_LEN-BLK_LEN:0]     tag_o,
    output logic                            done_o,
    output logic                            err_o
);

    localparam int LINE_W = 128;
    localparam int BEATS  = LINE_W / BUS_W;
    localparam int SZ     = $clog2(BUS_W / 8);
    localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int NB_W   = $clog2(BEATS + 1);
    localparam int TAG_W  = 32 - IDX_LEN - BLK_LEN;

    // Lowest address bit that the engine needs to remember.
`ifdef ICACHE_REFILL_WRAP_EN
    localparam int AL = SZ;
`else
    localparam int AL = BLK_LEN;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_AR,
        S_R,
        S_WR,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [31:AL]        addr_q, addr_d;
    logic [LINE_W-1:0]   buf_q, buf_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [NB_W-1:0]     nbeat_q, nbeat_d;
    logic                err_q, err_d;
    logic [CNT_W-1:0]    cnt_start;
    logic [CNT_W-1:0]    cnt_next;
    logic                unused_addr;

    // Byte-offset bits below the stored address never influence the refill.
    assign unused_addr = ^req_addr_i[AL-1:0];

    // First buffer slot to fill: the critical word when wrapping, else slot 0.
`ifdef ICACHE_REFILL_WRAP_EN
    assign cnt_start = addr_q[BLK_LEN-1:SZ];
`else
    assign cnt_start = '0;
`endif

    assign cnt_next = (int'(cnt_q) == BEATS - 1) ? '0 : cnt_q + 1'b1;

    // Array-side payload comes straight from registers so it is never X.
    assign line_index_o = addr_q[BLK_LEN +: IDX_LEN];
    assign tag_o        = addr_q[31 -: TAG_W];
    assign line_wdata_o = buf_q;

    // State and datapath registers; reset abandons any burst in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            buf_q   <= '0;
            cnt_q   <= '0;
            nbeat_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            buf_q   <= buf_d;
            cnt_q   <= cnt_d;
            nbeat_q <= nbeat_d;
            err_q   <= err_d;
        end
    end

    // Next-state, beat capture, error tracking and per-state outputs.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        buf_d        = buf_q;
        cnt_d        = cnt_q;
        nbeat_d      = nbeat_q;
        err_d        = err_q;
        req_ready_o  = 1'b0;
        arvalid_o    = 1'b0;
        araddr_o     = '0;
        arlen_o      = '0;
        arsize_o     = '0;
        arburst_o    = '0;
        rready_o     = 1'b0;
        line_wen_o   = 1'b0;
        line_wmask_o = '0;
        tag_wen_o    = 1'b0;
        done_o       = 1'b0;
        err_o        = 1'b0;

        case (state_q)
            S_IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    addr_d  = req_addr_i[31:AL];
                    err_d   = 1'b0;
                    state_d = S_AR;
                end
            end

            S_AR: begin
                arvalid_o = 1'b1;
                araddr_o  = {addr_q, {AL{1'b0}}};
                arlen_o   = 8'(BEATS - 1);
                arsize_o  = 3'(SZ);
`ifdef ICACHE_REFILL_WRAP_EN
                arburst_o = 2'b10;
`else
                arburst_o = 2'b01;
`endif
                if (arready_i) begin
                    cnt_d   = cnt_start;
                    nbeat_d = '0;
                    state_d = S_R;
                end
            end

            S_R: begin
                rready_o = 1'b1;
                if (rvalid_i) begin
                    buf_d[int'(cnt_q)*BUS_W +: BUS_W] = rdata_i;
                    cnt_d = cnt_next;
                    if (nbeat_q != NB_W'(BEATS)) begin
                        nbeat_d = nbeat_q + 1'b1;
                    end
                    if (rresp_i != 2'b00) begin
                        err_d = 1'b1;
                    end
                    if (rlast_i) begin
                        // Only a clean burst of exactly BEATS beats is written.
                        if (nbeat_q == NB_W'(BEATS - 1) && !err_q && rresp_i == 2'b00) begin
                            state_d = S_WR;
                        end else begin
                            err_d   = 1'b1;
                            state_d = S_DONE;
                        end
                    end else if (nbeat_q >= NB_W'(BEATS - 1)) begin
                        // Slave overran the line; keep draining until rlast.
                        err_d = 1'b1;
                    end
                end
            end

            S_WR: begin
                line_wen_o   = 1'b1;
                line_wmask_o = '1;
                tag_wen_o    = 1'b1;
                state_d      = S_DONE;
            end

            S_DONE: begin
                done_o  = 1'b1;
                err_o   = err_q;
                err_d   = 1'b0;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule
